// File: rtl/button_event_queue.sv
// Collects debounced button press pulses, serialises them by fixed priority and queues their indices.
// Optional per-event 16-bit timestamps when BTN_EVENT_TIMESTAMP_EN is defined.
module button_event_queue #(
  parameter int NUM_BTN = 5,
  parameter int DEPTH   = 8,
  parameter int CODE_W  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         btn_pulse,
  input  logic                       ev_ready,
  input  logic                       ovf_clr,
  output logic                       ev_valid,
  output logic [CODE_W-1:0]          ev_code,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
`ifdef BTN_EVENT_TIMESTAMP_EN
  ,
  output logic [15:0]                ev_time
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [CODE_W-1:0]  mem_q [DEPTH];
  logic [CODE_W-1:0]  mem_d [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;

  logic               pop;
  logic               push;
  logic               found;
  logic [CODE_W-1:0]  sel;
  logic [NUM_BTN-1:0] sel_onehot;
  logic [NUM_BTN-1:0] clr_mask;
  logic [NUM_BTN-1:0] dup;

`ifdef BTN_EVENT_TIMESTAMP_EN
  logic [15:0] ts_q, ts_d;
  logic [15:0] tmem_q [DEPTH];
  logic [15:0] tmem_d [DEPTH];
`endif

  always_comb begin
    found      = 1'b0;
    sel        = '0;
    sel_onehot = '0;
    // Lowest index wins when several presses are pending.
    for (int i = 0; i < NUM_BTN; i++) begin
      if (pending_q[i] && !found) begin
        found         = 1'b1;
        sel           = CODE_W'(i);
        sel_onehot[i] = 1'b1;
      end
    end

    pop  = (count_q != '0) && ev_ready;
    push = found && ((count_q < CW'(DEPTH)) || pop);

    clr_mask  = push ? sel_onehot : '0;
    dup       = btn_pulse & pending_q & ~clr_mask;
    pending_d = (pending_q & ~clr_mask) | btn_pulse;

    if (|dup)        overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
    else             overflow_d = overflow_q;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = sel;

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

`ifdef BTN_EVENT_TIMESTAMP_EN
    ts_d   = ts_q + 16'd1;
    tmem_d = tmem_q;
    if (push) tmem_d[wr_ptr_q] = ts_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
`ifdef BTN_EVENT_TIMESTAMP_EN
      ts_q       <= '0;
`endif
    end else begin
      pending_q  <= pending_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef BTN_EVENT_TIMESTAMP_EN
      ts_q       <= ts_d;
`endif
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
`ifdef BTN_EVENT_TIMESTAMP_EN
    tmem_q <= tmem_d;
`endif
  end

  assign ev_valid   = (count_q != '0);
  assign ev_code    = ev_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
`ifdef BTN_EVENT_TIMESTAMP_EN
  assign ev_time    = ev_valid ? tmem_q[rd_ptr_q] : '0;
`endif

endmodule
